target_decoder: RTL and testbench

- Sequential decoder that expands the 32-bit compact difficulty field (nBits) from the block header into the full 256-bit target.
- Its target output drives the target input of the hash-vs-target comparator, which asserts valid when SHA output < target.
- Expansion uses a byte-serial shifter (one byte per clock) with a start/busy/done handshake.
- Target output is held stable between decodes.

---
 rtl/target_decoder.sv | 145 ++++++++++++++
 tb/tb_target_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/target_decoder.sv
// target_decoder
// Expands the 32-bit compact difficulty field (nBits) of a block header into
// the full 256-bit target used by the hash-vs-target comparator. The mantissa
// is moved into place one byte per clock. target/negative/overflow only
// change on the cycle the FSM enters DONE, so the comparator never sees an
// intermediate value while a decode is in progress.

module target_decoder #(
   parameter int TARGET_W = 256
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [31:0]         nbits,
   output logic [TARGET_W-1:0] target,
   output logic                busy,
   output logic                done,
   output logic                negative,
   output logic                overflow
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [31:0]           nbits_q;     // compact field captured on the start edge
   logic [TARGET_W-1:0]   work_q;      // byte-serial shifter
   logic [7:0]            cnt_q;       // byte shifts still to perform
   logic                  left_q;      // 1: shift toward MSB, 0: toward LSB
   logic                  neg_q;
   logic                  ovf_q;
   logic [TARGET_W-1:0]   target_q;
   logic                  negative_q;
   logic                  overflow_q;

   // Fields of the captured compact value and everything LOAD needs
   logic [7:0]            exp_s;
   logic [22:0]           mant_s;
   logic                  mant_nz_s;
   logic                  neg_d;
   logic                  ovf_d;
   logic                  left_d;
   logic [7:0]            dist_s;
   logic [7:0]            cnt_d;
   logic [TARGET_W-1:0]   work_d;

   // Decode exponent/mantissa, derive shift direction/count and error flags
   always_comb begin
      exp_s     = nbits_q[31:24];
      mant_s    = nbits_q[22:0];
      mant_nz_s = (mant_s != 23'd0);
      neg_d     = nbits_q[23] & mant_nz_s;
      // A result wider than 256 bits: any mantissa past E=34, more than one
      // significant byte at E=34, more than two at E=33.
      ovf_d     = mant_nz_s & ((exp_s > 8'd34) |
                               ((mant_s > 23'h0000FF) & (exp_s > 8'd33)) |
                               ((mant_s > 23'h00FFFF) & (exp_s > 8'd32)));
      if (exp_s >= 8'd3) begin
         left_d = 1'b1;
         dist_s = exp_s - 8'd3;
      end else begin
         left_d = 1'b0;
         dist_s = 8'd3 - exp_s;
      end
      // Error results are forced to zero, so skip the shifting entirely.
      if (neg_d | ovf_d) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = dist_s;
      end
      work_d = {{(TARGET_W-23){1'b0}}, mant_s};
   end

   // Decode FSM: capture, load shifter, shift one byte per clock, publish
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         nbits_q    <= 32'd0;
         work_q     <= {TARGET_W{1'b0}};
         cnt_q      <= 8'd0;
         left_q     <= 1'b0;
         neg_q      <= 1'b0;
         ovf_q      <= 1'b0;
         target_q   <= {TARGET_W{1'b0}};
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  nbits_q <= nbits;
                  state_q <= ST_LOAD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               work_q  <= work_d;
               cnt_q   <= cnt_d;
               left_q  <= left_d;
               neg_q   <= neg_d;
               ovf_q   <= ovf_d;
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (cnt_q != 8'd0) begin
                  if (left_q) begin
                     work_q <= work_q << 8;
                  end else begin
                     work_q <= work_q >> 8;
                  end
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  if (neg_q | ovf_q) begin
                     target_q <= {TARGET_W{1'b0}};
                  end else begin
                     target_q <= work_q;
                  end
                  negative_q <= neg_q;
                  overflow_q <= ovf_q;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               // start is deliberately not looked at here
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign target   = target_q;
   assign negative = negative_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_target_decoder.sv
// Scoreboard bench for target_decoder: the driver pushes the expected result
// of every accepted request; a monitor pops and compares on each done pulse
// and checks that outputs hold steady on every other cycle.

module tb_target_decoder;

   logic         clk;
   logic         n_rst;
   logic         start;
   logic [31:0]  nbits;
   logic [255:0] target;
   logic         busy;
   logic         done;
   logic         negative;
   logic         overflow;

   target_decoder #(.TARGET_W(256)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .nbits    (nbits),
      .target   (target),
      .busy     (busy),
      .done     (done),
      .negative (negative),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] tgt;
      logic         neg;
      logic         ovf;
      int           lat;
      longint       e0;
   } exp_t;

   exp_t         sb_q[$];
   longint       cyc = 0;
   int           checks = 0;
   int           passed = 0;
   logic [255:0] hold_t = 256'd0;
   logic         hold_n = 1'b0;
   logic         hold_o = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   // Reference: value = M * 256^(E-3) computed in a very wide integer;
   // overflow means any bit above 255 is set.
   function automatic exp_t model(input logic [31:0] nb);
      exp_t          r;
      int            e;
      logic [22:0]   m;
      logic [2079:0] wide;
      e    = int'(nb[31:24]);
      m    = nb[22:0];
      wide = 2080'(m);
      if (e >= 3) wide = wide << (8 * (e - 3));
      else        wide = wide >> (8 * (3 - e));
      r.neg = nb[23] && (m != 23'd0);
      r.ovf = (m != 23'd0) && (wide[2079:256] != 1824'd0);
      r.tgt = (r.neg || r.ovf) ? 256'd0 : wide[255:0];
      r.lat = (r.neg || r.ovf) ? 2 : 2 + ((e >= 3) ? e - 3 : 3 - e);
      r.e0  = 0;
      return r;
   endfunction

   // Monitor: compare on done, otherwise outputs must hold the last result
   always @(negedge clk) begin
      exp_t e;
      if (!n_rst) begin
         sb_q.delete();
         hold_t = 256'd0;
         hold_n = 1'b0;
         hold_o = 1'b0;
      end else if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 256'(done), 256'd0);
         end else begin
            e = sb_q.pop_front();
            chk("target", target, e.tgt);
            chk("negative", 256'(negative), 256'(e.neg));
            chk("overflow", 256'(overflow), 256'(e.ovf));
            chk("latency", 256'(cyc - e.e0), 256'(e.lat));
            hold_t = e.tgt;
            hold_n = e.neg;
            hold_o = e.ovf;
         end
      end else begin
         chk("hold_target", target, hold_t);
         chk("hold_flags", {254'd0, negative, overflow}, {254'd0, hold_n, hold_o});
      end
   end

   longint issue_e0;

   task automatic issue(input logic [31:0] nb);
      exp_t e;
      int   w;
      w = 0;
      @(negedge clk);
      while (busy && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (busy) chk("idle_timeout", 256'(busy), 256'd0);
      start    = 1'b1;
      nbits    = nb;
      e        = model(nb);
      e.e0     = cyc + 1;
      issue_e0 = e.e0;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      nbits = $urandom;  // later changes must not matter
   endtask

   task automatic wait_done(output longint lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!done && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (!done) chk("done_timeout", 256'(done), 256'd1);
      lat = cyc - issue_e0;
   endtask

   typedef struct {
      logic [31:0]  nb;
      logic [255:0] tgt;
      logic         neg;
      logic         ovf;
      int           lat;
   } dir_t;

   dir_t dirs[8];

   initial begin
      longint       lat;
      logic [255:0] tmp;
      logic [7:0]   e;
      logic [22:0]  m;
      int           cls;

      dirs[0] = '{32'h1d00ffff, 256'hFFFF << 208, 1'b0, 1'b0, 28};
      dirs[1] = '{32'h03123456, 256'h123456,      1'b0, 1'b0, 2};
      dirs[2] = '{32'h01123456, 256'h12,          1'b0, 1'b0, 4};
      dirs[3] = '{32'h22000001, 256'd1 << 248,    1'b0, 1'b0, 33};
      dirs[4] = '{32'h23000001, 256'd0,           1'b0, 1'b1, 2};
      dirs[5] = '{32'h2200FFFF, 256'd0,           1'b0, 1'b1, 2};
      dirs[6] = '{32'h04923456, 256'd0,           1'b1, 1'b0, 2};
      dirs[7] = '{32'h04800000, 256'd0,           1'b0, 1'b0, 3};

      n_rst = 1'b0;
      start = 1'b0;
      nbits = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_target", target, 256'd0);
      chk("reset_busy", 256'(busy), 256'd0);
      chk("reset_done", 256'(done), 256'd0);
      chk("reset_flags", {254'd0, negative, overflow}, 256'd0);
      #1 n_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 256'(busy), 256'd0);

      // Directed cases against constants
      foreach (dirs[i]) begin
         issue(dirs[i].nb);
         wait_done(lat);
         chk("dir_target", target, dirs[i].tgt);
         chk("dir_flags", {254'd0, negative, overflow}, {254'd0, dirs[i].neg, dirs[i].ovf});
         chk("dir_latency", 256'(lat), 256'(dirs[i].lat));
         if (i == 0) begin
            tmp = dirs[0].tgt - 256'd1;
            chk("cmp_below", 256'(tmp < target), 256'd1);
            tmp = dirs[0].tgt;
            chk("cmp_equal", 256'(tmp < target), 256'd0);
         end
      end

      // start mid-decode and on the DONE cycle is ignored
      issue(32'h1d00ffff);
      repeat (10) @(negedge clk);
      start = 1'b1;
      nbits = 32'h03000001;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      start = 1'b1;
      nbits = 32'h03000001;
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", 256'(busy), 256'd0);
      chk("ign_target", target, 256'hFFFF << 208);
      repeat (5) @(negedge clk);
      chk("ign_still_idle", 256'(busy), 256'd0);

      // Reset in the middle of SHIFT
      issue(32'h1d00ffff);
      repeat (8) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("mid_rst_target", target, 256'd0);
      chk("mid_rst_busy", 256'(busy), 256'd0);
      chk("mid_rst_done", 256'(done), 256'd0);
      chk("mid_rst_flags", {254'd0, negative, overflow}, 256'd0);
      @(negedge clk);
      #1 n_rst = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_idle", 256'(busy), 256'd0);

      // Randomized requests, biased toward the interesting exponents
      for (int k = 0; k < 150; k++) begin
         cls = $urandom_range(0, 9);
         e   = (cls == 9) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 36));
         case ($urandom_range(0, 4))
            0:       m = 23'($urandom_range(0, 255));
            1:       m = 23'($urandom_range(0, 65535));
            2:       m = 23'd0;
            default: m = 23'($urandom);
         endcase
         if (m == 23'd0 && e > 8'd40) e = 8'd40;
         issue({e, 1'($urandom_range(0, 1)), m});
      end
      wait_done(lat);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 256'(sb_q.size()), 256'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
